// File: rtl/alu_pkg.sv
// Shared types for the execute stage: ALU control encoding, op-code map and FSM states.
package alu_pkg;

   typedef enum logic [2:0] {
      ALU_SUB  = 3'b000,
      ALU_ADD  = 3'b001,
      ALU_MUL  = 3'b010,
      ALU_DIV  = 3'b011,
      ALU_AND  = 3'b100,
      ALU_SLL  = 3'b101,
      ALU_SRL  = 3'b110,
      ALU_MOVB = 3'b111
   } alu_ctrl_e;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_e;

   localparam logic [3:0] OP_SUB  = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_MUL  = 4'b0010;
   localparam logic [3:0] OP_DIV  = 4'b0011;
   localparam logic [3:0] OP_AND  = 4'b0100;
   localparam logic [3:0] OP_SLL  = 4'b0101;
   localparam logic [3:0] OP_SRL  = 4'b0110;
   localparam logic [3:0] OP_ADDI = 4'b0111;
   localparam logic [3:0] OP_ADDR = 4'b1000;
   localparam logic [3:0] OP_CMP  = 4'b1100;
   localparam logic [3:0] OP_MOVB = 4'b1101;

   function automatic alu_ctrl_e decode_op(input logic [3:0] op);
      alu_ctrl_e c;
      case (op)
         OP_SUB:  c = ALU_SUB;
         OP_ADD:  c = ALU_ADD;
         OP_MUL:  c = ALU_MUL;
         OP_DIV:  c = ALU_DIV;
         OP_AND:  c = ALU_AND;
         OP_SLL:  c = ALU_SLL;
         OP_SRL:  c = ALU_SRL;
         OP_ADDI: c = ALU_ADD;
         OP_ADDR: c = ALU_ADD;
         OP_CMP:  c = ALU_SUB;
         OP_MOVB: c = ALU_MOVB;
         default: c = ALU_SUB;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned multiply (shift-add) / restoring divide, one bit per cycle over WIDTH cycles.
module alu_iter_muldiv
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             start,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] res
);

   localparam int CNT_W = $clog2(WIDTH);

   logic             running;
   logic             div_mode;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] acc, x, y;
   logic [WIDTH-1:0] acc_nxt, x_nxt, y_nxt;
   logic [WIDTH:0]   part;
   logic [WIDTH-1:0] trial;
   logic             ge;

   // acc is the product for MUL and the partial remainder for DIV; x holds multiplicand / quotient
   always_comb begin
      part    = {acc, x[WIDTH-1]};
      ge      = (part >= {1'b0, y});
      trial   = part[WIDTH-1:0] - y;
      acc_nxt = acc;
      x_nxt   = x;
      y_nxt   = y;
      if (div_mode) begin
         acc_nxt = ge ? trial : part[WIDTH-1:0];
         x_nxt   = {x[WIDTH-2:0], ge};
      end else begin
         acc_nxt = acc + (y[0] ? x : '0);
         x_nxt   = x << 1;
         y_nxt   = y >> 1;
      end
   end

   assign done = running && (count == CNT_W'(WIDTH - 1));
   assign res  = div_mode ? x_nxt : acc_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         running  <= 1'b0;
         div_mode <= 1'b0;
         count    <= '0;
         acc      <= '0;
         x        <= '0;
         y        <= '0;
      end else if (flush) begin
         running <= 1'b0;
         count   <= '0;
      end else if (start) begin
         running  <= 1'b1;
         div_mode <= is_div;
         count    <= '0;
         acc      <= '0;
         x        <= a;
         y        <= b;
      end else if (running) begin
         acc   <= acc_nxt;
         x     <= x_nxt;
         y     <= y_nxt;
         count <= count + 1'b1;
         if (done) running <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: op decode, single-cycle ALU, NZCV flags, iterative MUL/DIV, valid/ready handshake.
// ALU_FAST_MUL_EN: when defined, MUL is a single-cycle combinational multiply.
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags,
   output logic             div_by_zero
);

   localparam int SHAMT_W = $clog2(WIDTH);

   state_e           state, state_nxt;
   alu_ctrl_e        ctrl;
   logic             accept;
   logic             iter_op;
   logic             start;
   logic             load_out;
   logic             dbz_pend;
   logic             dbz_nxt;
   logic             iter_done;
   logic [WIDTH-1:0] iter_res;
   logic [WIDTH:0]   sum, diff;
   logic [WIDTH-1:0] sc_result;
   logic             sc_c, sc_v;
   logic [WIDTH-1:0] res_nxt;
   logic [3:0]       flags_nxt;

   assign ctrl      = decode_op(op);
   assign in_ready  = (state == IDLE) && !flush;
   assign accept    = in_valid && in_ready;
   assign out_valid = (state == DONE);

`ifdef ALU_FAST_MUL_EN
   assign iter_op = (ctrl == ALU_DIV);
`else
   assign iter_op = (ctrl == ALU_DIV) || (ctrl == ALU_MUL);
`endif

   always_comb begin
      sum       = {1'b0, a} + {1'b0, b};
      diff      = {1'b0, a} - {1'b0, b};
      sc_result = '0;
      sc_c      = 1'b0;
      sc_v      = 1'b0;
      case (ctrl)
         ALU_ADD: begin
            sc_result = sum[WIDTH-1:0];
            sc_c      = sum[WIDTH];
            sc_v      = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         ALU_SUB: begin
            sc_result = diff[WIDTH-1:0];
            sc_c      = ~diff[WIDTH];
            sc_v      = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         ALU_AND:  sc_result = a & b;
         ALU_SLL:  sc_result = a << b[SHAMT_W-1:0];
         ALU_SRL:  sc_result = a >> b[SHAMT_W-1:0];
         ALU_MOVB: sc_result = b;
`ifdef ALU_FAST_MUL_EN
         ALU_MUL:  sc_result = a * b;
`endif
         default:  sc_result = '0;
      endcase
   end

   alu_iter_muldiv #(
      .WIDTH (WIDTH)
   ) u_iter (
      .clk    (clk),
      .rst    (rst),
      .flush  (flush),
      .start  (start),
      .is_div (ctrl == ALU_DIV),
      .a      (a),
      .b      (b),
      .done   (iter_done),
      .res    (iter_res)
   );

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      load_out  = 1'b0;
      res_nxt   = sc_result;
      flags_nxt = {sc_result[WIDTH-1], (sc_result == '0), sc_c, sc_v};
      dbz_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (iter_op) begin
                  start     = 1'b1;
                  state_nxt = BUSY;
               end else begin
                  load_out  = 1'b1;
                  state_nxt = DONE;
               end
            end
         end
         BUSY: begin
            if (iter_done) begin
               load_out  = 1'b1;
               res_nxt   = iter_res;
               flags_nxt = {iter_res[WIDTH-1], (iter_res == '0), 2'b00};
               dbz_nxt   = dbz_pend;
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // flush overrides any retire/accept decided above
      if (flush) begin
         state_nxt = IDLE;
         start     = 1'b0;
         load_out  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         result      <= '0;
         flags       <= '0;
         div_by_zero <= 1'b0;
         dbz_pend    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (load_out) begin
            result      <= res_nxt;
            flags       <= flags_nxt;
            div_by_zero <= dbz_nxt;
         end
         if (accept) dbz_pend <= (ctrl == ALU_DIV) && (b == '0);
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit (WIDTH=32).
module tb_alu_exec_unit;
   import alu_pkg::*;

   localparam int W = 32;
`ifdef ALU_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b1;
   logic [3:0]    op = '0;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          in_ready, out_valid, div_by_zero;
   logic [W-1:0]  result;
   logic [3:0]    flags;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [3:0]  fl;
      logic        dbz;
      int          lat;
   } vec_t;

   vec_t vecs[18];

   alu_exec_unit #(
      .WIDTH (W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .op          (op),
      .a           (a),
      .b           (b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .flags       (flags),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_before_op", {31'b0, in_ready}, 32'd1);
   endtask

   // latency counts clock edges from the accept edge (inclusive) until out_valid is seen
   task automatic do_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] r, output logic [3:0] f, output logic z, output int lat);
      wait_ready();
      op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      r = result; f = flags; z = div_by_zero;
   endtask

   initial begin
      logic [31:0] r;
      logic [3:0]  f;
      logic        z;
      int          lat;
      int          seen;

      vecs[0]  = '{OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001, 1'b0, 1};
      vecs[1]  = '{OP_CMP,  32'h00000005, 32'h00000005, 32'h00000000, 4'b0110, 1'b0, 1};
      vecs[2]  = '{4'hF,    32'h00000003, 32'h00000005, 32'hFFFFFFFE, 4'b1000, 1'b0, 1};
      vecs[3]  = '{OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110, 1'b0, 1};
      vecs[4]  = '{OP_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011, 1'b0, 1};
      vecs[5]  = '{OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b1000, 1'b0, 1};
      vecs[6]  = '{OP_SLL,  32'h00000001, 32'h00000023, 32'h00000008, 4'b0000, 1'b0, 1};
      vecs[7]  = '{OP_SRL,  32'h80000000, 32'h0000001F, 32'h00000001, 4'b0000, 1'b0, 1};
      vecs[8]  = '{OP_MOVB, 32'h00000005, 32'h00000000, 32'h00000000, 4'b0100, 1'b0, 1};
      vecs[9]  = '{OP_ADDI, 32'h00000002, 32'h00000003, 32'h00000005, 4'b0000, 1'b0, 1};
      vecs[10] = '{OP_ADDR, 32'h00001000, 32'h00000024, 32'h00001024, 4'b0000, 1'b0, 1};
      vecs[11] = '{OP_MUL,  32'h00010000, 32'h00010001, 32'h00010000, 4'b0000, 1'b0, MUL_LAT};
      vecs[12] = '{OP_MUL,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 4'b1000, 1'b0, MUL_LAT};
      vecs[13] = '{OP_DIV,  32'd100,      32'd7,        32'd14,       4'b0000, 1'b0, 33};
      vecs[14] = '{OP_DIV,  32'd5,        32'd0,        32'hFFFFFFFF, 4'b1000, 1'b1, 33};
      vecs[15] = '{OP_DIV,  32'd7,        32'd9,        32'd0,        4'b0100, 1'b0, 33};
      vecs[16] = '{4'h9,    32'd10,       32'd3,        32'd7,        4'b0010, 1'b0, 1};
      vecs[17] = '{OP_DIV,  32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 4'b1000, 1'b0, 33};

      // reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_flags", {28'b0, flags}, 32'd0);
      check("rst_dbz", {31'b0, div_by_zero}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);

      for (int i = 0; i < 18; i++) begin
         do_op(vecs[i].op, vecs[i].a, vecs[i].b, r, f, z, lat);
         check($sformatf("v%0d_result", i), r, vecs[i].res);
         check($sformatf("v%0d_flags", i), {28'b0, f}, {28'b0, vecs[i].fl});
         check($sformatf("v%0d_dbz", i), {31'b0, z}, {31'b0, vecs[i].dbz});
         check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      end

      // consumer stall: outputs held, no new accept
      wait_ready();
      op = OP_ADD; a = 32'h7FFFFFFF; b = 32'h1; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("stall_first_valid", {31'b0, out_valid}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("stall_valid", {31'b0, out_valid}, 32'd1);
         check("stall_result", result, 32'h80000000);
         check("stall_flags", {28'b0, flags}, 32'h9);
         check("stall_in_ready", {31'b0, in_ready}, 32'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("stall_release_valid", {31'b0, out_valid}, 32'd0);
      check("stall_release_ready", {31'b0, in_ready}, 32'd1);

      // flush at BUSY cycle 10
      wait_ready();
      op = OP_DIV; a = 32'd100; b = 32'd7; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      #1;
      check("flush_in_ready_low", {31'b0, in_ready}, 32'd0);
      @(posedge clk); #1;
      check("flush_valid", {31'b0, out_valid}, 32'd0);
      @(negedge clk);
      flush = 1'b0;
      #1;
      check("flush_idle_ready", {31'b0, in_ready}, 32'd1);
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      check("flush_no_valid", seen, 0);

      // reset in the middle of a divide
      do_op(OP_DIV, 32'd5, 32'd0, r, f, z, lat);
      wait_ready();
      op = OP_DIV; a = 32'd100; b = 32'd7; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_valid", {31'b0, out_valid}, 32'd0);
      check("midrst_result", result, 32'd0);
      check("midrst_flags", {28'b0, flags}, 32'd0);
      check("midrst_dbz", {31'b0, div_by_zero}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      do_op(OP_DIV, 32'd100, 32'd7, r, f, z, lat);
      check("postrst_result", r, 32'd14);
      check("postrst_dbz", {31'b0, z}, 32'd0);
      check("postrst_latency", lat, 33);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
